// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide: WIDTH shift-add/subtract steps on magnitudes, then one sign-fix cycle.
// Define MULDIV_FAST_MULT_EN to route MULT/MULTU through a single-cycle multiplier (division stays iterative).
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  state_t state, nextState;

  logic [CW-1:0]      count;
  logic               isDiv, negA, negB, divByZero;
  logic [WIDTH-1:0]   rawA, stepOperand, accHi, accLo;
  logic [WIDTH-1:0]   hiReg, loReg;
  logic               doneReg, divZeroReg;
  logic               accept, startMulDiv, startSigned, lastStep;
  logic [WIDTH-1:0]   magA, magB;
  logic [WIDTH:0]     addSum, remShift;
  logic [WIDTH-1:0]   remDiff;
  logic               remGe;
  logic [2*WIDTH-1:0] prodMag, prodSigned;
  logic [WIDTH-1:0]   finHi, finLo;

  assign accept      = (state == IDLE) && Start;
  assign startMulDiv = accept && !Op[2];
  assign startSigned = !Op[0];
  assign lastStep    = (count == CW'(WIDTH - 1));
  // Unsigned WIDTH-bit magnitude still represents -2^(WIDTH-1) exactly.
  assign magA = (startSigned && OperandA[WIDTH-1]) ? -OperandA : OperandA;
  assign magB = (startSigned && OperandB[WIDTH-1]) ? -OperandB : OperandB;

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (startMulDiv) begin
`ifdef MULDIV_FAST_MULT_EN
          nextState = Op[1] ? RUN : FINISH;
`else
          nextState = RUN;
`endif
        end
      end
      RUN:     if (lastStep) nextState = FINISH;
      FINISH:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    Busy    = (state != IDLE);
    Done    = doneReg;
    DivZero = divZeroReg;
    Hi      = hiReg;
    Lo      = loReg;
  end

  // One iteration step: accHi is the partial product / running remainder, accLo the multiplier / quotient.
  always_comb begin
    addSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, stepOperand} : '0);
    remShift = {accHi, accLo[WIDTH-1]};
    remGe    = (remShift >= {1'b0, stepOperand});
    remDiff  = remShift[WIDTH-1:0] - stepOperand;
  end

  always_comb begin
`ifdef MULDIV_FAST_MULT_EN
    prodMag = {{WIDTH{1'b0}}, stepOperand} * {{WIDTH{1'b0}}, accLo};
`else
    prodMag = {accHi, accLo};
`endif
    prodSigned = (negA ^ negB) ? -prodMag : prodMag;
    finHi = prodSigned[2*WIDTH-1:WIDTH];
    finLo = prodSigned[WIDTH-1:0];
    if (isDiv) begin
      if (divByZero) begin
        finHi = rawA;
        finLo = '1;
      end else begin
        finHi = negA ? -accHi : accHi;
        finLo = (negA ^ negB) ? -accLo : accLo;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count       <= '0;
      isDiv       <= 1'b0;
      negA        <= 1'b0;
      negB        <= 1'b0;
      divByZero   <= 1'b0;
      rawA        <= '0;
      stepOperand <= '0;
      accHi       <= '0;
      accLo       <= '0;
      hiReg       <= '0;
      loReg       <= '0;
      doneReg     <= 1'b0;
      divZeroReg  <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      case (state)
        IDLE: begin
          if (startMulDiv) begin
            count       <= '0;
            isDiv       <= Op[1];
            negA        <= startSigned && OperandA[WIDTH-1];
            negB        <= startSigned && OperandB[WIDTH-1];
            divByZero   <= Op[1] && (OperandB == '0);
            rawA        <= OperandA;
            divZeroReg  <= 1'b0;
            accHi       <= '0;
            accLo       <= Op[1] ? magA : magB;
            stepOperand <= Op[1] ? magB : magA;
          end else if (accept && Op == 3'd4) begin
            hiReg <= OperandA;
          end else if (accept && Op == 3'd5) begin
            loReg <= OperandA;
          end
        end
        RUN: begin
          count <= count + 1'b1;
          if (isDiv) begin
            accHi <= remGe ? remDiff : remShift[WIDTH-1:0];
            accLo <= {accLo[WIDTH-2:0], remGe};
          end else begin
            accHi <= addSum[WIDTH:1];
            accLo <= {addSum[0], accLo[WIDTH-1:1]};
          end
        end
        FINISH: begin
          hiReg   <= finHi;
          loReg   <= finLo;
          doneReg <= 1'b1;
          if (isDiv && divByZero) divZeroReg <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
